// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Request/response front end for the CPU data memory. Accepts
//               one read or write at a time over valid/ready, drives the
//               array pins, returns one response per request, and can sweep
//               the array to zero after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] c_ST_CLEAR = 3'd0;
    localparam logic [2:0] c_ST_IDLE  = 3'd1;
    localparam logic [2:0] c_ST_WRITE = 3'd2;
    localparam logic [2:0] c_ST_READ  = 3'd3;
    localparam logic [2:0] c_ST_RESP  = 3'd4;

    localparam logic [2:0]        c_RESET_STATE = (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_IDLE;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR   = {ADDR_W{1'b1}};

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_valid;
    logic              w_mem_we;
    logic              w_req_ready;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // State register; reset restarts the sweep (or goes straight to idle)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and array-pin decode from the current state
    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        w_req_ready  = 1'b0;
        w_mem_addr   = r_addr;
        w_mem_wdata  = r_wdata;
        case (r_state)
            c_ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_cnt;
                w_mem_wdata = '0;
                if (r_clr_cnt == c_LAST_ADDR) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = req_we ? c_ST_WRITE : c_ST_READ;
                end
            end
            c_ST_WRITE: begin
                w_mem_we     = 1'b1;
                w_next_state = c_ST_RESP;
            end
            c_ST_READ: begin
                w_next_state = c_ST_RESP;
            end
            c_ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Sweep counter, request latch and response register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_cnt   <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (r_state == c_ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if ((r_state == c_ST_IDLE) && req_valid) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == c_ST_WRITE) begin
                r_rsp_rdata <= r_wdata;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == c_ST_READ) begin
                r_rsp_rdata <= mem_rdata;
                r_rsp_valid <= 1'b1;
            end
            if ((r_state == c_ST_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Reset gating keeps a reset landing in WRITE from corrupting the array
    assign mem_we    = rst_n & w_mem_we;
    assign req_ready = rst_n & w_req_ready;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = w_mem_wdata;
    assign busy      = (r_state != c_ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl, with a
//               behavioural 4-word array behind each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic       clk;
    // Instance with the post-reset sweep
    logic       rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, busy, mem_we;
    logic [1:0] req_addr, mem_addr;
    logic [7:0] req_wdata, rsp_rdata, mem_wdata, mem_rdata;
    logic [7:0] mem [4];
    // Instance without the sweep
    logic       rst_n2, req_valid2, req_ready2, req_we2, rsp_valid2, rsp_ready2, busy2, mem_we2;
    logic [1:0] req_addr2, mem_addr2;
    logic [7:0] req_wdata2, rsp_rdata2, mem_wdata2, mem_rdata2;
    logic [7:0] mem2 [4];

    int n_pass = 0;
    int n_total = 0;

    mem_access_ctrl #(.DATA_W(8), .ADDR_W(2), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.DATA_W(8), .ADDR_W(2), .CLEAR_ON_RESET(0)) dut2 (
        .clk(clk), .rst_n(rst_n2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2),
        .busy(busy2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural arrays: synchronous write, combinational read
    always @(posedge clk) if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    always @(posedge clk) if (mem_we2 === 1'b1) mem2[mem_addr2] <= mem_wdata2;
    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata2 = mem2[mem_addr2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full request on the first instance with rsp_ready held high
    task automatic do_req(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        check("req_ready_idle", req_ready, 1);
        step();                                   // E0: accept
        req_valid = 1'b0;
        check("mem_we_op", mem_we, we);
        check("mem_addr_op", mem_addr, addr);
        if (we) check("mem_wdata_op", mem_wdata, wd);
        check("rsp_valid_e0", rsp_valid, 0);
        step();                                   // E1: response
        check("rsp_valid_e1", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, exp_rd);
        step();                                   // consumed, back to IDLE
        check("rsp_valid_done", rsp_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        rst_n2 = 1'b0; req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0; rsp_ready2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem[i]  = 8'hAA;
            mem2[i] = 8'hAA;
        end

        // T1: reset, then zero-fill sweep
        step();
        check("rst_mem_we", mem_we, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("clr_mem_we", mem_we, 1);
            check("clr_mem_addr", mem_addr, i);
            check("clr_mem_wdata", mem_wdata, 0);
            check("clr_busy", busy, 1);
            check("clr_req_ready", req_ready, 0);
            step();
        end
        check("post_clr_ready", req_ready, 1);
        check("post_clr_busy", busy, 0);
        for (int i = 0; i < 4; i++) check("clr_contents", mem[i], 0);
        for (int i = 0; i < 4; i++) do_req(1'b0, 2'(i), 8'h00, 8'h00);

        // T2: write then read-after-write
        do_req(1'b1, 2'd2, 8'h5A, 8'h5A);
        do_req(1'b0, 2'd2, 8'h00, 8'h5A);

        // T3: response back-pressure; a request arriving meanwhile is ignored
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd2;
        step();
        req_we = 1'b1; req_addr = 2'd0; req_wdata = 8'hEE;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 8'h5A);
            check("bp_req_ready", req_ready, 0);
            check("bp_mem_we", mem_we, 0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("bp_released", rsp_valid, 0);
        step();
        check("bp_single_rsp", rsp_valid, 0);
        check("bp_ignored_wr", mem[0], 0);

        // T4: back-to-back writes then reads, 3-cycle cadence
        do_req(1'b1, 2'd0, 8'h11, 8'h11);
        do_req(1'b1, 2'd1, 8'h22, 8'h22);
        do_req(1'b1, 2'd2, 8'h33, 8'h33);
        do_req(1'b1, 2'd3, 8'h44, 8'h44);
        do_req(1'b0, 2'd0, 8'h00, 8'h11);
        do_req(1'b0, 2'd1, 8'h00, 8'h22);
        do_req(1'b0, 2'd2, 8'h00, 8'h33);
        do_req(1'b0, 2'd3, 8'h00, 8'h44);

        // T5: reset lands while in WRITE
        req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd1; req_wdata = 8'hFF;
        step();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_mem_we_gated", mem_we, 0);
        check("t5_req_ready", req_ready, 0);
        step();
        check("t5_no_write", mem[1], 8'h22);
        check("t5_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t5_clr_addr", mem_addr, i);
            check("t5_clr_we", mem_we, 1);
            check("t5_no_rsp_clr", rsp_valid, 0);
            step();
        end
        do_req(1'b0, 2'd1, 8'h00, 8'h00);

        // T6: instance without sweep
        step();
        check("t6_rst_ready", req_ready2, 0);
        rst_n2 = 1'b1;
        #1;
        check("t6_ready_now", req_ready2, 1);
        check("t6_busy", busy2, 0);
        check("t6_mem_we", mem_we2, 0);
        for (int i = 0; i < 4; i++) check("t6_untouched", mem2[i], 8'hAA);
        req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = 2'd3; rsp_ready2 = 1'b1;
        step();
        req_valid2 = 1'b0;
        step();
        check("t6_rsp_valid", rsp_valid2, 1);
        check("t6_rsp_rdata", rsp_rdata2, 8'hAA);
        step();
        check("t6_rsp_done", rsp_valid2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
